// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: per-source edge/level capture, enable mask, lowest-index vector.
// Writes land on the next clk edge and reads are combinational; interrupt lags pending/enable by one register.
module irq_controller #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               select,
    input  logic [3:0]         wr,
    input  logic [1:0]         addr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               interrupt
);

    localparam logic [1:0] ADDR_VECTOR  = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_MODE    = 2'd3;

    logic [NUM_IRQ-1:0] enable_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] mode_q;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] wr_data;
    logic               wr_en;
    logic               clr_pend;
    logic [2:0]         vec_idx;
    logic               unused_bits;

    assign wr_en       = select & wr[0];
    assign clr_pend    = wr_en && (addr == ADDR_PENDING);
    assign wr_data     = data_in[NUM_IRQ-1:0];
    assign active      = pending_q & enable_q;
    assign unused_bits = ^{wr[3:1], data_in};

    // Edge sources: a fresh edge beats a simultaneous W1C. Level sources ignore W1C.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (mode_q[i]) begin
                if (irq_in[i] && !prev_q[i])
                    pending_d[i] = 1'b1;
                else if (clr_pend && wr_data[i])
                    pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = irq_in[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q  <= '0;
            pending_q <= '0;
            mode_q    <= '0;
            prev_q    <= '0;
            interrupt <= 1'b0;
        end else begin
            prev_q    <= irq_in;
            pending_q <= pending_d;
            interrupt <= |active;
            if (wr_en) begin
                case (addr)
                    ADDR_ENABLE: enable_q <= wr_data;
                    ADDR_MODE:   mode_q   <= wr_data;
                    default:     ;
                endcase
            end
        end
    end

    // Scan downward so the lowest active index is the last one written.
    always_comb begin
        vec_idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i])
                vec_idx = 3'(i);
        end
    end

    always_comb begin
        data_out = 32'h0;
        if (select) begin
            case (addr)
                ADDR_VECTOR: begin
                    data_out[31]  = |active;
                    data_out[2:0] = vec_idx;
                end
                ADDR_ENABLE:  data_out[NUM_IRQ-1:0] = enable_q;
                ADDR_PENDING: data_out[NUM_IRQ-1:0] = pending_q;
                ADDR_MODE:    data_out[NUM_IRQ-1:0] = mode_q;
                default:      data_out = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: full-width instance plus a 4-source instance sharing the bus.
module tb_irq_controller;

    logic        clk;
    logic        reset;
    logic        select;
    logic [3:0]  wr;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [7:0]  irq_in;
    logic        interrupt;
    logic [31:0] data_out4;
    logic        interrupt4;

    int checks = 0;
    int errors = 0;

    irq_controller #(.NUM_IRQ(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .select    (select),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .irq_in    (irq_in),
        .interrupt (interrupt)
    );

    irq_controller #(.NUM_IRQ(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .select    (select),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out4),
        .irq_in    (irq_in[3:0]),
        .interrupt (interrupt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] strobes = 4'b0001);
        select  = 1'b1;
        wr      = strobes;
        addr    = a;
        data_in = d;
        tick();
        select  = 1'b0;
        wr      = 4'b0000;
        data_in = 32'h0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        select = 1'b1;
        addr   = a;
        #1;
        check(tag, data_out, exp);
        select = 1'b0;
    endtask

    task automatic rd_check4(input string tag, input logic [1:0] a, input logic [31:0] exp);
        select = 1'b1;
        addr   = a;
        #1;
        check(tag, data_out4, exp);
        select = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        select  = 1'b0;
        wr      = 4'b0000;
        addr    = 2'd0;
        data_in = 32'h0;
        irq_in  = 8'h00;
        #1 reset = 1'b1;
        #1;
        check("rst_interrupt", {31'h0, interrupt}, 32'h0);
        check("rst_dout_unselected", data_out, 32'h0);
        rd_check("rst_enable", 2'd1, 32'h0);
        rd_check("rst_vector", 2'd0, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Level source 0: two-cycle latency on both rise and fall
        bus_write(2'd1, 32'h0000_0001);
        irq_in = 8'h01;
        tick();
        check("lvl_irq_after1", {31'h0, interrupt}, 32'h0);
        tick();
        check("lvl_irq_after2", {31'h0, interrupt}, 32'h1);
        rd_check("lvl_vector", 2'd0, 32'h8000_0000);
        rd_check("lvl_pending", 2'd2, 32'h0000_0001);
        irq_in = 8'h00;
        tick();
        check("lvl_fall_after1", {31'h0, interrupt}, 32'h1);
        tick();
        check("lvl_fall_after2", {31'h0, interrupt}, 32'h0);

        // Edge source 2: pulse latched, then cleared by W1C
        bus_write(2'd3, 32'h0000_0004);
        bus_write(2'd1, 32'hFFFF_FF04);
        rd_check("edge_enable_rb", 2'd1, 32'h0000_0004);
        rd_check("edge_mode_rb", 2'd3, 32'h0000_0004);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        tick();
        check("edge_irq", {31'h0, interrupt}, 32'h1);
        rd_check("edge_pending", 2'd2, 32'h0000_0004);
        rd_check("edge_vector", 2'd0, 32'h8000_0002);
        tick();
        check("edge_irq_held", {31'h0, interrupt}, 32'h1);
        bus_write(2'd2, 32'h0000_0004);
        rd_check("edge_pending_clr", 2'd2, 32'h0000_0000);
        check("edge_irq_lag", {31'h0, interrupt}, 32'h1);
        tick();
        check("edge_irq_clr", {31'h0, interrupt}, 32'h0);
        bus_write(2'd0, 32'hFFFF_FFFF);
        rd_check("vector_ro", 2'd0, 32'h0000_0000);

        // Edge on source 5 coincides with W1C of the same bit
        bus_write(2'd3, 32'h0000_0020);
        irq_in = 8'h20;
        bus_write(2'd2, 32'h0000_0020);
        irq_in = 8'h00;
        rd_check("collide_pending", 2'd2, 32'h0000_0020);
        bus_write(2'd2, 32'h0000_0020);
        rd_check("collide_clr_later", 2'd2, 32'h0000_0000);

        // Priority among level sources 3 and 6
        bus_write(2'd3, 32'h0000_0000);
        bus_write(2'd1, 32'h0000_00FF);
        irq_in = 8'h48;
        tick();
        rd_check("prio_vector_ff", 2'd0, 32'h8000_0003);
        rd_check4("n4_enable", 2'd1, 32'h0000_000F);
        rd_check4("n4_pending", 2'd2, 32'h0000_0008);
        rd_check4("n4_vector", 2'd0, 32'h8000_0003);
        bus_write(2'd1, 32'h0000_00F0);
        rd_check("prio_vector_f0", 2'd0, 32'h8000_0006);
        rd_check4("n4_vector_masked", 2'd0, 32'h0000_0000);
        bus_write(2'd2, 32'h0000_00FF);
        rd_check("lvl_w1c_ignored", 2'd2, 32'h0000_0048);
        tick();
        check("n4_irq_masked", {31'h0, interrupt4}, 32'h0);
        irq_in = 8'h00;
        tick();

        // Masked edge on source 0, then unmask
        bus_write(2'd3, 32'h0000_0001);
        bus_write(2'd1, 32'h0000_0000);
        bus_write(2'd1, 32'h0000_00FF, 4'b1110);
        rd_check("upper_strobes_ignored", 2'd1, 32'h0000_0000);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        tick();
        rd_check("mask_pending", 2'd2, 32'h0000_0001);
        check("mask_irq_low", {31'h0, interrupt}, 32'h0);
        rd_check("mask_vector", 2'd0, 32'h0000_0000);
        bus_write(2'd1, 32'h0000_0001);
        check("unmask_lag", {31'h0, interrupt}, 32'h0);
        tick();
        check("unmask_irq", {31'h0, interrupt}, 32'h1);

        // Reset mid-operation with pending 0x81
        bus_write(2'd3, 32'h0000_0081);
        bus_write(2'd1, 32'h0000_0081);
        irq_in = 8'h81;
        tick();
        irq_in = 8'h00;
        tick();
        rd_check("pre_rst_pending", 2'd2, 32'h0000_0081);
        check("pre_rst_irq", {31'h0, interrupt}, 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_irq", {31'h0, interrupt}, 32'h0);
        rd_check("mid_rst_pending", 2'd2, 32'h0);
        rd_check("mid_rst_enable", 2'd1, 32'h0);
        rd_check("mid_rst_mode", 2'd3, 32'h0);
        rd_check("mid_rst_vector", 2'd0, 32'h0);

        // Source 1 held high through reset release must not produce an edge later
        irq_in = 8'h02;
        tick();
        tick();
        reset = 1'b0;
        tick();
        rd_check("held_level_pending", 2'd2, 32'h0000_0002);
        bus_write(2'd3, 32'h0000_0002);
        bus_write(2'd2, 32'h0000_0002);
        tick();
        tick();
        rd_check("held_no_edge", 2'd2, 32'h0000_0000);
        irq_in = 8'h00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt sources (legal range 1..8).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port select  input  1  bus address decode hit for this block.
REQ-005 SHALL have port wr  input  4  CPU byte write strobes; a write occurs when select && wr[0].
REQ-006 SHALL have port addr  input  2  register index (CPU word address bits [3:2]).
REQ-007 SHALL have port data_in  input  32  CPU write data.
REQ-008 SHALL have port data_out  output  32  register read data.
REQ-009 SHALL have port irq_in  input  NUM_IRQ  interrupt source lines, synchronous to clk, active-high.
REQ-010 SHALL have port interrupt  output  1  interrupt request to the CPU, active-high.

Function
REQ-011 SHALL implement registers: addr 0 VECTOR (RO), 1 ENABLE (RW), 2 PENDING (R, W1C), 3 MODE (RW; bit n=1 edge, 0 level).
REQ-012 SHALL ignore wr[3:1]; only data_in[NUM_IRQ-1:0] is used on writes; unused read bits return 0.
REQ-013 SHALL register irq_in into prev[] every cycle, independent of MODE.
REQ-014 Edge source n: pending[n] SHALL be set in the cycle after irq_in[n] && !prev[n].
REQ-015 Edge source n: a PENDING write with data_in[n]=1 SHALL clear pending[n] on the next edge.
REQ-016 Simultaneous edge detect and W1C on the same bit SHALL leave pending[n]=1 (set wins).
REQ-017 Level source n: pending[n] SHALL equal irq_in[n] registered one cycle; W1C SHALL have no effect.
REQ-018 A MODE write changing edge to level SHALL make pending[n] follow irq_in from the next cycle; level to edge SHALL retain the current pending value until cleared.
REQ-019 Pending SHALL be captured regardless of ENABLE; ENABLE only gates the output.
REQ-020 interrupt SHALL be a register equal to |(pending & enable), i.e. one cycle after pending/enable change (edge-to-interrupt latency 2 cycles).
REQ-021 VECTOR read SHALL return bit31 = |(pending & enable), bits[2:0] = lowest-numbered index with pending&enable set (0 when none), other bits 0.
REQ-022 Reads SHALL have no side effects; data_out SHALL be combinational from addr and current state when select=1, and 32'h0 when select=0.
REQ-023 Writes to addr 0 SHALL be ignored.
REQ-024 Source indices >= NUM_IRQ SHALL read as 0 in every register and never assert interrupt.

Reset
REQ-025 On reset SHALL clear enable, pending, mode (all level), prev and interrupt to 0, immediately (asynchronously).
REQ-026 Reset asserted mid-operation SHALL discard all pending events; an edge source held high through reset release SHALL NOT generate an edge event once switched to edge mode.
REQ-027 data_out SHALL be 0 during reset when select=0; register reads during reset SHALL return reset values.

Verification
REQ-028 Level: ENABLE=0x01, raise irq_in[0] -> interrupt=1 two cycles later, VECTOR=0x80000000; drop irq_in[0] -> interrupt=0 two cycles later.
REQ-029 Edge: MODE=0x04, ENABLE=0x04, 1-cycle pulse on irq_in[2] -> PENDING=0x04, VECTOR=0x80000002, interrupt held; write PENDING=0x04 -> PENDING=0x00, interrupt=0 next cycle.
REQ-030 Set-vs-clear collision: edge on irq_in[5] in the same cycle as W1C 0x20 (MODE=0x20) -> PENDING remains 0x20.
REQ-031 Priority: ENABLE=0xFF, level sources 3 and 6 high -> VECTOR=0x80000003; ENABLE=0xF0 -> VECTOR=0x80000006.
REQ-032 Masking: MODE=0x01, ENABLE=0x00, pulse irq_in[0] -> PENDING=0x01, interrupt=0; write ENABLE=0x01 -> interrupt=1 next cycle.
REQ-033 Reset mid-operation: pending 0x81 and interrupt=1, assert reset -> interrupt=0 and all registers read 0 without a clock edge.
